// File: rtl/booth_pkg.sv
// Shared types and constants for the booth multiplier host sequencer.
package booth_pkg;

    // Operand and product widths of the booth core.
    localparam int OPND_W = 8;

    // Protocol shape: the host sends M then Q, the core returns hi then lo.
    localparam int OPND_BEATS = 2;
    localparam int RES_BEATS  = 2;

    localparam int PROD_W = OPND_W * RES_BEATS;

    // Host sequencer states, in protocol order.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_M = 3'd1,
        ST_SEND_Q = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CAP_LO = 3'd4,
        ST_DONE   = 3'd5
    } booth_host_state_t;

    // Reassemble the product from its two result beats, high byte first.
    function automatic logic [PROD_W-1:0] join_bytes(input logic [OPND_W-1:0] hi,
                                                     input logic [OPND_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/booth_host_if.sv
// Signal bundle between the booth host, the issuing datapath and the booth core.
interface booth_host_if;
    import booth_pkg::*;

    // Operand handshake from the issuing datapath.
    logic              op_valid;
    logic              op_ready;
    logic [OPND_W-1:0] op_a;
    logic [OPND_W-1:0] op_b;

    // Result handshake towards downstream.
    logic              res_valid;
    logic              res_ready;
    logic [PROD_W-1:0] res_data;
    logic              res_err;

    // Booth core protocol.
    logic              bgn;
    logic [OPND_W-1:0] ibus;
    logic [OPND_W-1:0] obus;
    logic              stop;

    // The host drives handshake replies and the core's bgn/ibus.
    modport slave (
        input  op_valid, op_a, op_b, res_ready, obus, stop,
        output op_ready, res_valid, res_data, res_err, bgn, ibus
    );

    // The datapath/core side: the mirror image of the host.
    modport master (
        output op_valid, op_a, op_b, res_ready, obus, stop,
        input  op_ready, res_valid, res_data, res_err, bgn, ibus
    );

endinterface

// File: rtl/booth_host_timer.sv
// Clearable up-counter with terminal-count flag, bounding the wait for the core.
module booth_host_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] count;

    // Clear wins over enable; the sequencer leaves WAIT at terminal count, so no wrap.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/booth_host.sv
// Host-side sequencer for the booth multiplier core: issues M/Q, collects the
// two-byte product while stop is high and hands a 16-bit result downstream.
module booth_host
    import booth_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_b,
    booth_host_if.slave hif
);

    // Keep the wait window long enough to cover the protocol beats and within
    // the range the timer is sized for.
    localparam int TIMEOUT_MIN = OPND_BEATS + RES_BEATS;
    localparam int TIMEOUT_EFF = (TIMEOUT < TIMEOUT_MIN) ? TIMEOUT_MIN :
                                 (TIMEOUT > 255)         ? 255 : TIMEOUT;

    booth_host_state_t state;

    logic              op_ready_q;
    logic              bgn_q;
    logic [OPND_W-1:0] ibus_q;
    logic              res_valid_q;
    logic [PROD_W-1:0] res_data_q;
    logic              res_err_q;

    // Q is held until its beat; M goes straight into the ibus register.
    logic [OPND_W-1:0] q_lat;
    // High result byte, held until the low byte arrives.
    logic [OPND_W-1:0] p_hi;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_tc;

    // The timer restarts as Q is sent and counts only while waiting for stop.
    assign tmr_clr = (state == ST_SEND_Q);
    assign tmr_en  = (state == ST_WAIT);

    booth_host_timer #(
        .TIMEOUT (TIMEOUT_EFF)
    ) u_timer (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    // Protocol sequencer; every output is a register updated on the transition.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= ST_IDLE;
            op_ready_q  <= 1'b0;
            bgn_q       <= 1'b0;
            ibus_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            q_lat       <= '0;
            p_hi        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every branch reads the pre-edge
            // state and outputs; blocking here would chain updates within one edge.
            case (state)
                ST_IDLE: begin
                    op_ready_q <= 1'b1;
                    // op_ready_q is still low on the first edge out of reset, so no
                    // accept can happen before op_ready is visible.
                    if (hif.op_valid && op_ready_q) begin
                        op_ready_q <= 1'b0;
                        bgn_q      <= 1'b1;
                        ibus_q     <= hif.op_a;
                        q_lat      <= hif.op_b;
                        state      <= ST_SEND_M;
                    end
                end

                ST_SEND_M: begin
                    bgn_q  <= 1'b0;
                    ibus_q <= q_lat;
                    state  <= ST_SEND_Q;
                end

                ST_SEND_Q: begin
                    ibus_q <= '0;
                    state  <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (hif.stop) begin
                        p_hi  <= hif.obus;
                        state <= ST_CAP_LO;
                    end else if (tmr_tc) begin
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                        res_data_q  <= '0;
                        state       <= ST_DONE;
                    end
                end

                ST_CAP_LO: begin
                    res_valid_q <= 1'b1;
                    if (hif.stop) begin
                        res_data_q <= join_bytes(p_hi, hif.obus);
                        res_err_q  <= 1'b0;
                    end else begin
                        // stop dropped after one beat: the low byte never came.
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                    end
                    state <= ST_DONE;
                end

                ST_DONE: begin
                    if (hif.res_ready) begin
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        op_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hif.op_ready  = op_ready_q;
    assign hif.bgn       = bgn_q;
    assign hif.ibus      = ibus_q;
    assign hif.res_valid = res_valid_q;
    assign hif.res_data  = res_data_q;
    assign hif.res_err   = res_err_q;

endmodule

// File: tb/tb_booth_host.sv
// Directed bench for booth_host with a behavioural booth core of configurable stop latency.
module tb_booth_host;
    import booth_pkg::*;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    booth_host_if hif();

    booth_host #(
        .TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .hif   (hif)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Core model controls: mode 0 normal, 1 never stops, 2 stop for one cycle only.
    int core_mode = 0;
    int core_lat  = 0;

    // Behavioural booth core: samples M/Q mid-cycle, drives stop/obus just after edges.
    initial begin
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] p;
        hif.stop = 1'b0;
        hif.obus = 8'h00;
        forever begin
            @(negedge clk);
            if (hif.bgn === 1'b1) begin
                m = hif.ibus;
                @(negedge clk);
                q = hif.ibus;
                p = {{8{m[7]}}, m} * {{8{q[7]}}, q};
                if (core_mode != 1) begin
                    @(posedge clk);
                    repeat (core_lat) @(posedge clk);
                    #1;
                    hif.stop = 1'b1;
                    hif.obus = p[15:8];
                    @(posedge clk);
                    #1;
                    if (core_mode == 0) begin
                        hif.obus = p[7:0];
                        @(posedge clk);
                        #1;
                    end
                    hif.stop = 1'b0;
                    hif.obus = 8'h00;
                end
            end
        end
    end

    // Offer one operand pair; the host must be in IDLE with op_ready high.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        hif.op_a     = a;
        hif.op_b     = b;
        hif.op_valid = 1'b1;
        @(posedge clk);
        #1;
        hif.op_valid = 1'b0;
        hif.op_a     = 8'hA5;
        hif.op_b     = 8'h5A;
    endtask

    // Count cycles (sampled at negedge) until res_valid; -1 if it never comes.
    task automatic wait_result(input int start, output int n);
        n = start;
        while (hif.res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (hif.res_valid !== 1'b1) n = -1;
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_data, input logic exp_err, input int exp_lat);
        int n;
        issue(a, b);
        wait_result(0, n);
        tests_run++;
        if (n !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
        end
        tests_run++;
        if (hif.res_data !== exp_data) begin
            tests_failed++;
            $display("FAIL %s res_data: got %h expected %h", name, hif.res_data, exp_data);
        end
        tests_run++;
        if (hif.res_err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s res_err: got %b expected %b", name, hif.res_err, exp_err);
        end
        @(negedge clk);
        tests_run++;
        if (hif.res_valid !== 1'b0 || hif.op_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s release: got res_valid=%b op_ready=%b expected 0/1",
                     name, hif.res_valid, hif.op_ready);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({hif.op_ready, hif.bgn, hif.ibus, hif.res_valid, hif.res_data, hif.res_err} !== 28'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got op_ready=%b bgn=%b ibus=%h res_valid=%b res_data=%h res_err=%b expected all 0",
                     hif.op_ready, hif.bgn, hif.ibus, hif.res_valid, hif.res_data, hif.res_err);
        end
        rst_b = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hif.op_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release op_ready: got %b expected 1", hif.op_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        issue(8'h02, 8'h03);
        @(negedge clk);
        tests_run++;
        if (hif.bgn !== 1'b1 || hif.ibus !== 8'h02) begin
            tests_failed++;
            $display("FAIL send_m: got bgn=%b ibus=%h expected 1/02", hif.bgn, hif.ibus);
        end
        @(negedge clk);
        tests_run++;
        if (hif.bgn !== 1'b0 || hif.ibus !== 8'h03) begin
            tests_failed++;
            $display("FAIL send_q: got bgn=%b ibus=%h expected 0/03", hif.bgn, hif.ibus);
        end
        @(negedge clk);
        tests_run++;
        if (hif.ibus !== 8'h00) begin
            tests_failed++;
            $display("FAIL wait_ibus: got %h expected 00", hif.ibus);
        end
        wait_result(3, n);
        tests_run++;
        if (n !== 5) begin
            tests_failed++;
            $display("FAIL basic latency: got %0d expected 5", n);
        end
        tests_run++;
        if (hif.res_data !== 16'h0006 || hif.res_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic result: got %h err=%b expected 0006 err=0", hif.res_data, hif.res_err);
        end
        @(negedge clk);
        tests_run++;
        if (hif.res_valid !== 1'b0 || hif.op_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic one_cycle_valid: got res_valid=%b op_ready=%b expected 0/1",
                     hif.res_valid, hif.op_ready);
        end
    endtask

    task automatic test_products();
        run_op("neg_times_pos", 8'hFD, 8'h05, 16'hFFF1, 1'b0, 5);
        run_op("min_times_min", 8'h80, 8'h80, 16'h4000, 1'b0, 5);
        core_lat = 3;
        run_op("latency3", 8'h0C, 8'hF6, 16'hFF88, 1'b0, 8);
        core_lat = 0;
    endtask

    task automatic test_timeout();
        core_mode = 1;
        run_op("timeout", 8'h12, 8'h34, 16'h0000, 1'b1, 67);
        core_mode = 0;
        run_op("after_timeout", 8'h07, 8'hFE, 16'hFFF2, 1'b0, 5);
    endtask

    task automatic test_single_stop();
        core_mode = 2;
        run_op("single_stop", 8'h7F, 8'h7F, 16'h0000, 1'b1, 5);
        core_mode = 0;
    endtask

    task automatic test_backpressure();
        int n;
        hif.res_ready = 1'b0;
        issue(8'h10, 8'h10);
        wait_result(0, n);
        tests_run++;
        if (n !== 5) begin
            tests_failed++;
            $display("FAIL hold latency: got %0d expected 5", n);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (hif.res_valid !== 1'b1 || hif.res_data !== 16'h0100 ||
                hif.res_err !== 1'b0 || hif.op_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold cycle %0d: got res_valid=%b res_data=%h res_err=%b op_ready=%b expected 1/0100/0/0",
                         i, hif.res_valid, hif.res_data, hif.res_err, hif.op_ready);
            end
        end
        hif.res_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hif.res_valid !== 1'b0 || hif.op_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold release: got res_valid=%b op_ready=%b expected 0/1",
                     hif.res_valid, hif.op_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a_tab [4];
        logic [7:0]  b_tab [4];
        logic [15:0] p_tab [4];
        int acc_cyc [4];
        int j;
        int r;
        a_tab = '{8'h02, 8'hFF, 8'h7F, 8'h00};
        b_tab = '{8'h03, 8'hFF, 8'h80, 8'h55};
        p_tab = '{16'h0006, 16'h0001, 16'hC080, 16'h0000};
        acc_cyc = '{0, 0, 0, 0};
        j = 0;
        r = 0;
        for (int cyc = 0; cyc < 80 && r < 4; cyc++) begin
            if (hif.res_valid === 1'b1) begin
                tests_run++;
                if (hif.res_data !== p_tab[r] || hif.res_err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b result %0d: got %h err=%b expected %h err=0",
                             r, hif.res_data, hif.res_err, p_tab[r]);
                end
                r++;
            end
            if (j < 4 && hif.op_ready === 1'b1) begin
                hif.op_a     = a_tab[j];
                hif.op_b     = b_tab[j];
                hif.op_valid = 1'b1;
                acc_cyc[j]   = cyc;
                j++;
            end else begin
                hif.op_valid = 1'b0;
            end
            @(negedge clk);
        end
        hif.op_valid = 1'b0;
        tests_run++;
        if (r !== 4) begin
            tests_failed++;
            $display("FAIL b2b result count: got %0d expected 4", r);
        end
        for (int i = 1; i < 4; i++) begin
            tests_run++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
                tests_failed++;
                $display("FAIL b2b interval %0d: got %0d expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        core_lat = 10;
        issue(8'h11, 8'h22);
        repeat (5) @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        tests_run++;
        if ({hif.op_ready, hif.bgn, hif.ibus, hif.res_valid, hif.res_data, hif.res_err} !== 28'd0) begin
            tests_failed++;
            $display("FAIL midreset outputs: got op_ready=%b bgn=%b ibus=%h res_valid=%b res_data=%h res_err=%b expected all 0",
                     hif.op_ready, hif.bgn, hif.ibus, hif.res_valid, hif.res_data, hif.res_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        // The model's delayed stop burst lands inside this window and must be ignored.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            tests_run++;
            if (hif.op_ready !== 1'b1 || hif.res_valid !== 1'b0 || hif.bgn !== 1'b0) begin
                tests_failed++;
                $display("FAIL stale_stop cycle %0d: got op_ready=%b res_valid=%b bgn=%b expected 1/0/0",
                         i, hif.op_ready, hif.res_valid, hif.bgn);
            end
        end
        core_lat = 0;
        run_op("after_reset", 8'h09, 8'h09, 16'h0051, 1'b0, 5);
    endtask

    initial begin
        hif.op_valid  = 1'b0;
        hif.op_a      = 8'h00;
        hif.op_b      = 8'h00;
        hif.res_ready = 1'b1;
        test_reset();
        test_basic();
        test_products();
        test_timeout();
        test_single_stop();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_host.md
# booth_host

Host-side sequencer for the `booth` multiplier core. It accepts an 8-bit operand pair over a valid/ready handshake and drives the core's `bgn`/`ibus` side of the protocol. It then collects the two-byte product from `obus` while `stop` is asserted, and presents a 16-bit signed result downstream. It sits between the datapath issuing multiplies and the `booth` instance, and is the only block that drives that instance's `bgn` and `ibus`.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before aborting; valid range 4..255.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_b`  in  1  reset, asynchronous and active-low.
- `op_valid`  in  1  operand pair offered.
- `op_ready`  out  1  host can accept an operand pair.
- `op_a`  in  8  multiplicand M, two's complement.
- `op_b`  in  8  multiplier Q, two's complement.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  16  product M*Q, two's complement.
- `res_err`  out  1  qualifies `res_valid`: the transaction aborted.
- `bgn`  out  1  start strobe to the core.
- `ibus`  out  8  operand bus to the core.
- `obus`  in  8  result bus from the core.
- `stop`  in  1  core result-phase indicator.

## Operation
- Core protocol:
  - The host asserts `bgn` for exactly one cycle with `ibus`=M.
  - On the following cycle it presents `ibus`=Q.
  - The core later asserts `stop` for two consecutive cycles: the first with `obus`=P[15:8], the second with `obus`=P[7:0].
- State machine, one-hot or encoded:
  - IDLE: `op_ready`=1. On `op_valid`, latch `op_a`/`op_b` and go to SEND_M.
  - SEND_M: `bgn`=1, `ibus`=M. Go to SEND_Q.
  - SEND_Q: `bgn`=0, `ibus`=Q. Clear the timer. Go to WAIT.
  - WAIT: `ibus`=0; the timer increments.
    - If `stop`=1, capture `obus` into P[15:8] and go to CAP_LO.
    - Otherwise, if the timer equals TIMEOUT-1, go to DONE with err=1 and P=0.
  - CAP_LO:
    - If `stop`=1, capture `obus` into P[7:0] and go to DONE with err=0.
    - If `stop`=0 (protocol violation), go to DONE with err=1 and P=0.
  - DONE: `res_valid`=1 while holding `res_data`/`res_err`. On `res_ready`, go to IDLE.
- `stop` seen in IDLE, SEND_M or SEND_Q is ignored (stale), with no state change.
- Operands are latched only at acceptance, so changes on `op_a`/`op_b` afterwards have no effect.
- No arithmetic is done in the host. `res_data` is the captured bytes concatenated {hi, lo}, unmodified.

## Timing
- All outputs are registered and driven from state.
- Reset values: `op_ready`=0 during reset and 1 in the first cycle after release (IDLE); `bgn`=0, `ibus`=0, `res_valid`=0, `res_data`=0, `res_err`=0, timer=0, state=IDLE.
- Accept happens on edge k (`op_valid`&`op_ready`):
  - `bgn`=1 in cycle k+1.
  - `ibus`=Q in cycle k+2.
  - WAIT starts in cycle k+3.
- The first `stop` cycle at edge s yields `res_valid` in cycle s+2.
- Best-case accept-to-`res_valid` latency is 5 cycles.
- The timeout yields `res_valid`/`res_err` exactly TIMEOUT cycles after entering WAIT.
- Back-to-back operation: `res_ready`=1 in DONE returns the host to IDLE on the next edge, so `op_ready` is high one cycle after the result handshake. There is no same-cycle pass-through.
- If `res_ready` is held 1 on entry to DONE, `res_valid` lasts exactly one cycle.
- Reset asserted mid-transaction forces all outputs to their reset values immediately (asynchronously). The core is expected to share `rst_b`.

## Structure
- Shared package `booth_pkg`:
  - State enum `booth_host_state_t`.
  - `OPND_W`=8 and `PROD_W`=16.
  - Protocol constants: two operand beats, two result beats.
- One sub-module, `booth_host_timer`: a clearable up-counter with terminal-count output, width $clog2(TIMEOUT). It is cleared in SEND_Q and enabled in WAIT.
- The `booth` core is instantiated by the parent, not inside `booth_host`.

## Test plan
The bench pairs the host with the real `booth` core, or with a behavioural core model whose `stop` latency is configurable.

- Reset, then op_a=2, op_b=3 -> `bgn` pulse with `ibus`=0x02, next cycle `ibus`=0x03; `res_data`=0x0006, `res_err`=0.
- op_a=0xFD (-3), op_b=0x05 -> `res_data`=0xFFF1; op_a=0x80, op_b=0x80 -> `res_data`=0x4000.
- Model never asserts `stop`, TIMEOUT=64 -> `res_valid`=1, `res_err`=1, `res_data`=0 exactly 64 cycles after WAIT entry; next op completes normally.
- Model asserts `stop` for one cycle only -> `res_err`=1, `res_data`=0.
- `res_ready` held 0 for 10 cycles -> `res_valid`/`res_data` stable and `op_ready`=0 throughout; four back-to-back ops with `res_ready`=1 -> 6-cycle issue interval at zero core latency.
- `rst_b` pulled low during WAIT -> all outputs 0 immediately; after release `op_ready`=1 and the stale `stop` burst is ignored.
